lsu_align_unit: RTL and testbench

//  Memory-stage load/store alignment engine for the pipelined core. Accepts one access per

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_lane_extend.sv | 42 ++++
 rtl/lsu_align_unit.sv | 140 ++++++++++++++
 tb/tb_lsu_align_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store alignment unit: size codes, FSM states,
// lane-count limits and the byte-strobe generator.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } lsu_size_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BEAT0,
    ST_WAIT0,
    ST_BEAT1,
    ST_WAIT1,
    ST_RESP
  } lsu_state_t;

  localparam int MAX_NB     = 8;
  localparam int MAX_LOG_NB = 3;

  // Strobes for both beats at once: the low NB bits belong to beat0 and the
  // next NB bits to beat1, so a crossing access gets its spill-over for free.
  function automatic logic [2*MAX_NB-1:0] lane_mask(input logic [1:0] size,
                                                    input logic [MAX_LOG_NB-1:0] off);
    logic [2*MAX_NB-1:0] run;
    run = (16'(1) << (4'd1 << size)) - 16'(1);
    return run << off;
  endfunction

endpackage

// File: rtl/lsu_lane_extend.sv
// Load-data merge: joins the two bus beats, shifts the addressed bytes down to
// bit 0 and sign/zero-extends them to the full register width.
module lsu_lane_extend
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]              rdata0,
  input  logic [DATA_W-1:0]              rdata1,
  input  logic [$clog2(DATA_W/8)-1:0]    off,
  input  logic [1:0]                     size,
  input  logic                           unsign,
  output logic [DATA_W-1:0]              ext
);

  logic [DATA_W-1:0] merged;
  logic              sign_bit;
  logic              fill;
  int                keep_bits;

  // Beat1 sits above beat0, so one right shift lines up both halves of a split access.
  assign merged = DATA_W'({rdata1, rdata0} >> {off, 3'b000});

  always_comb begin
    sign_bit  = 1'b0;
    fill      = 1'b0;
    keep_bits = 8;
    ext       = '0;
    case (size)
      SZ_BYTE: sign_bit = merged[7];
      SZ_HALF: sign_bit = merged[15];
      SZ_WORD: sign_bit = merged[31];
      default: sign_bit = 1'b0;
    endcase
    fill      = sign_bit & ~unsign;
    keep_bits = 32'd8 << size;
    for (int i = 0; i < DATA_W; i++) begin
      ext[i] = (i < keep_bits) ? merged[i] : fill;
    end
  end

endmodule

// File: rtl/lsu_align_unit.sv
// Memory-stage load/store alignment engine. Define LSU_MISALIGN_SPLIT_EN to split
// bus-word-crossing accesses into two beats; otherwise misaligned accesses fault.
module lsu_align_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_we,
  input  logic [1:0]          i_req_size,
  input  logic                i_req_unsign,
  input  logic [ADDR_W-1:0]   i_req_addr,
  input  logic [DATA_W-1:0]   i_req_wdata,
  output logic                o_bus_valid,
  input  logic                i_bus_ready,
  output logic                o_bus_we,
  output logic [ADDR_W-1:0]   o_bus_addr,
  output logic [DATA_W-1:0]   o_bus_wdata,
  output logic [DATA_W/8-1:0] o_bus_mask,
  input  logic                i_bus_rvalid,
  input  logic [DATA_W-1:0]   i_bus_rdata,
  output logic                o_rsp_valid,
  output logic [DATA_W-1:0]   o_rsp_rdata,
  output logic                o_rsp_err
);

  localparam int NB     = DATA_W / 8;
  localparam int LOG_NB = $clog2(NB);

  lsu_state_t          state_reg, state_next;
  logic                we_reg, unsign_reg, split_reg, err_reg;
  logic [1:0]          size_reg;
  logic [ADDR_W-1:0]   base_reg;
  logic [LOG_NB-1:0]   off_reg;
  logic [DATA_W-1:0]   wdata_reg, rdata0_reg, rdata1_reg;

  logic [LOG_NB-1:0]   req_off;
  logic                req_split, align_bad, size_bad;

  assign req_off  = i_req_addr[LOG_NB-1:0];
  assign size_bad = (DATA_W == 32) && (i_req_size == SZ_DWORD);

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [4:0] req_end;
  assign req_end   = 5'(req_off) + (5'd1 << i_req_size);
  assign req_split = req_end > 5'(NB);
  assign align_bad = 1'b0;
`else
  logic [3:0] req_bytes;
  assign req_bytes = 4'd1 << i_req_size;
  assign req_split = 1'b0;
  assign align_bad = |(4'(req_off) & (req_bytes - 4'd1));
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg  <= ST_IDLE;
      we_reg     <= 1'b0;
      unsign_reg <= 1'b0;
      split_reg  <= 1'b0;
      err_reg    <= 1'b0;
      size_reg   <= 2'd0;
      base_reg   <= '0;
      off_reg    <= '0;
      wdata_reg  <= '0;
      rdata0_reg <= '0;
      rdata1_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && i_req_valid) begin
        we_reg     <= i_req_we;
        unsign_reg <= i_req_unsign;
        split_reg  <= req_split;
        err_reg    <= size_bad | align_bad;
        size_reg   <= i_req_size;
        base_reg   <= {i_req_addr[ADDR_W-1:LOG_NB], {LOG_NB{1'b0}}};
        off_reg    <= req_off;
        wdata_reg  <= i_req_wdata;
      end
      if (state_reg == ST_WAIT0 && i_bus_rvalid) rdata0_reg <= i_bus_rdata;
      if (state_reg == ST_WAIT1 && i_bus_rvalid) rdata1_reg <= i_bus_rdata;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (i_req_valid) state_next = (size_bad | align_bad) ? ST_RESP : ST_BEAT0;
      ST_BEAT0: if (i_bus_ready) begin
                  if (!we_reg)        state_next = ST_WAIT0;
                  else if (split_reg) state_next = ST_BEAT1;
                  else                state_next = ST_RESP;
                end
      ST_WAIT0: if (i_bus_rvalid) state_next = split_reg ? ST_BEAT1 : ST_RESP;
      ST_BEAT1: if (i_bus_ready)  state_next = we_reg ? ST_RESP : ST_WAIT1;
      ST_WAIT1: if (i_bus_rvalid) state_next = ST_RESP;
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  logic                in_beat1;
  logic [2*NB-1:0]     mask_pair;
  logic [LOG_NB+3:0]   hi_shift;
  logic [DATA_W-1:0]   beat_wdata;
  logic [DATA_W-1:0]   load_ext;

  assign in_beat1   = (state_reg == ST_BEAT1);
  assign mask_pair  = (2*NB)'(lane_mask(size_reg, 3'(off_reg)));
  // Beat1 carries whatever spilled past the top lane of beat0.
  assign hi_shift   = (LOG_NB+4)'(DATA_W) - (LOG_NB+4)'({off_reg, 3'b000});
  assign beat_wdata = in_beat1 ? (wdata_reg >> hi_shift) : (wdata_reg << {off_reg, 3'b000});

  assign o_req_ready = (state_reg == ST_IDLE);
  assign o_bus_valid = (state_reg == ST_BEAT0) || in_beat1;
  assign o_bus_we    = o_bus_valid & we_reg;
  assign o_bus_addr  = !o_bus_valid ? '0 : (in_beat1 ? base_reg + ADDR_W'(NB) : base_reg);
  assign o_bus_wdata = o_bus_we ? beat_wdata : '0;
  assign o_bus_mask  = !o_bus_valid ? '0 : (in_beat1 ? mask_pair[2*NB-1:NB] : mask_pair[NB-1:0]);

  lsu_lane_extend #(
    .DATA_W (DATA_W)
  ) u_lane_extend (
    .rdata0 (rdata0_reg),
    .rdata1 (rdata1_reg),
    .off    (off_reg),
    .size   (size_reg),
    .unsign (unsign_reg),
    .ext    (load_ext)
  );

  assign o_rsp_valid = (state_reg == ST_RESP);
  assign o_rsp_err   = o_rsp_valid & err_reg;
  assign o_rsp_rdata = (o_rsp_valid && !we_reg && !err_reg) ? load_ext : '0;

endmodule

// File: tb/tb_lsu_align_unit.sv
// Directed bench for lsu_align_unit (DATA_W=32): reset behaviour, lane placement,
// extension, stalls, faults, and split accesses when LSU_MISALIGN_SPLIT_EN is set.
module tb_lsu_align_unit;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_we = 1'b0;
  logic [1:0]  i_req_size = 2'd0;
  logic        i_req_unsign = 1'b0;
  logic [31:0] i_req_addr = '0;
  logic [31:0] i_req_wdata = '0;
  logic        o_bus_valid;
  logic        i_bus_ready = 1'b0;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [31:0] o_bus_wdata;
  logic [3:0]  o_bus_mask;
  logic        i_bus_rvalid = 1'b0;
  logic [31:0] i_bus_rdata = '0;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;

  always #5 i_clk = ~i_clk;

  lsu_align_unit #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_we     (i_req_we),
    .i_req_size   (i_req_size),
    .i_req_unsign (i_req_unsign),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .o_bus_valid  (o_bus_valid),
    .i_bus_ready  (i_bus_ready),
    .o_bus_we     (o_bus_we),
    .o_bus_addr   (o_bus_addr),
    .o_bus_wdata  (o_bus_wdata),
    .o_bus_mask   (o_bus_mask),
    .i_bus_rvalid (i_bus_rvalid),
    .i_bus_rdata  (i_bus_rdata),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_rdata  (o_rsp_rdata),
    .o_rsp_err    (o_rsp_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] obs_addr  [2];
  logic [31:0] obs_wdata [2];
  logic [3:0]  obs_mask  [2];
  int          nbeats, nvalid, lat;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        unstable;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one request and plays the bus slave; latency counts cycles after the accept edge.
  task automatic run_access(input logic we, input logic [1:0] sz, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rd0, input logic [31:0] rd1, input int stall);
    int          stall_left;
    logic        pend, holding;
    logic [31:0] h_addr, h_wdata;
    logic [3:0]  h_mask;
    stall_left = stall;
    pend = 1'b0; holding = 1'b0;
    h_addr = '0; h_wdata = '0; h_mask = '0;
    nbeats = 0; nvalid = 0; lat = -1; rsp_data = '0; rsp_err = 1'b0; unstable = 1'b0;
    for (int b = 0; b < 2; b++) begin
      obs_addr[b] = '0; obs_wdata[b] = '0; obs_mask[b] = '0;
    end
    i_req_valid = 1'b1; i_req_we = we; i_req_size = sz; i_req_unsign = uns;
    i_req_addr = addr; i_req_wdata = wd;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      i_bus_ready = 1'b0;
      i_bus_rvalid = 1'b0;
      if (pend) begin
        i_bus_rvalid = 1'b1;
        i_bus_rdata  = (nbeats == 1) ? rd0 : rd1;
        pend = 1'b0;
      end
      if (o_rsp_valid) begin
        lat = cyc; rsp_data = o_rsp_rdata; rsp_err = o_rsp_err;
        break;
      end
      if (o_bus_valid) begin
        nvalid++;
        if (!holding) begin
          holding = 1'b1; h_addr = o_bus_addr; h_wdata = o_bus_wdata; h_mask = o_bus_mask;
        end else if (o_bus_addr !== h_addr || o_bus_wdata !== h_wdata || o_bus_mask !== h_mask) begin
          unstable = 1'b1;
        end
        if (stall_left > 0) begin
          stall_left--;
        end else begin
          i_bus_ready = 1'b1;
          if (nbeats < 2) begin
            obs_addr[nbeats] = o_bus_addr; obs_wdata[nbeats] = o_bus_wdata; obs_mask[nbeats] = o_bus_mask;
          end
          nbeats++;
          holding = 1'b0;
          if (!o_bus_we) pend = 1'b1;
        end
      end
      @(posedge i_clk); #1;
    end
    i_bus_ready = 1'b0;
    i_bus_rvalid = 1'b0;
    @(posedge i_clk); #1;
    $display("txn we=%0d sz=%0d uns=%0d addr=0x%08h beats=%0d a0=0x%08h m0=%b a1=0x%08h m1=%b rsp=0x%08h err=%0d lat=%0d",
             we, sz, uns, addr, nbeats, obs_addr[0], obs_mask[0], obs_addr[1], obs_mask[1], rsp_data, rsp_err, lat);
  endtask

  initial begin
    logic saw_rsp;

    repeat (3) @(posedge i_clk);
    #1;
    check_eq("rst_req_ready", o_req_ready, 1);
    check_eq("rst_bus_valid", o_bus_valid, 0);
    check_eq("rst_rsp_valid", o_rsp_valid, 0);
    check_eq("rst_bus_mask",  o_bus_mask, 0);
    check_eq("rst_rsp_rdata", o_rsp_rdata, 0);
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    // Reset while a load is parked in BEAT0.
    i_req_valid = 1'b1; i_req_we = 1'b0; i_req_size = 2'd2; i_req_addr = 32'h200;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0; i_bus_ready = 1'b0;
    check_eq("midrst_valid_before", o_bus_valid, 1);
    #2 i_rst = 1'b1;
    #1;
    check_eq("midrst_valid_dropped", o_bus_valid, 0);
    check_eq("midrst_req_ready", o_req_ready, 1);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    saw_rsp = 1'b0;
    repeat (4) begin
      if (o_rsp_valid || o_bus_valid) saw_rsp = 1'b1;
      @(posedge i_clk); #1;
    end
    check_eq("midrst_no_rsp", saw_rsp, 0);
    $display("txn reset mid-BEAT0 addr=0x00000200 bus_valid_after=%0d", o_bus_valid);

    run_access(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80123456, 32'h0, 0);
    check_eq("lb_addr", obs_addr[0], 32'h100);
    check_eq("lb_mask", obs_mask[0], 4'b1000);
    check_eq("lb_rsp",  rsp_data, 32'hFFFFFF80);
    check_eq("lb_lat",  lat, 3);

    run_access(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80123456, 32'h0, 0);
    check_eq("lbu_rsp", rsp_data, 32'h00000080);

    run_access(1'b1, 2'd1, 1'b0, 32'h102, 32'hABCD1234, 32'h0, 32'h0, 0);
    check_eq("sh_addr",   obs_addr[0], 32'h100);
    check_eq("sh_mask",   obs_mask[0], 4'b1100);
    check_eq("sh_wdata",  obs_wdata[0], 32'h12340000);
    check_eq("sh_beats",  nbeats, 1);
    check_eq("sh_rsp",    rsp_data, 32'h0);
    check_eq("sh_lat",    lat, 2);

    run_access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 3);
    check_eq("stall_lat",    lat, 6);
    check_eq("stall_stable", unstable, 0);
    check_eq("stall_rsp",    rsp_data, 32'hDEADBEEF);
    check_eq("stall_mask",   obs_mask[0], 4'b1111);
    check_eq("stall_err",    rsp_err, 0);

    run_access(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'hF00D1234, 32'h0, 0);
    check_eq("lh_rsp", rsp_data, 32'hFFFFF00D);
    run_access(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'hF00D1234, 32'h0, 0);
    check_eq("lhu_rsp", rsp_data, 32'h0000F00D);

    run_access(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 0);
    check_eq("dword_err",    rsp_err, 1);
    check_eq("dword_lat",    lat, 1);
    check_eq("dword_no_bus", nvalid, 0);

`ifdef LSU_MISALIGN_SPLIT_EN
    run_access(1'b0, 2'd2, 1'b0, 32'h103, 32'h0, 32'hAA000000, 32'h00CCBBDD, 0);
    check_eq("split_lw_addr0", obs_addr[0], 32'h100);
    check_eq("split_lw_addr1", obs_addr[1], 32'h104);
    check_eq("split_lw_mask0", obs_mask[0], 4'b1000);
    check_eq("split_lw_mask1", obs_mask[1], 4'b0111);
    check_eq("split_lw_rsp",   rsp_data, 32'hCCBBDDAA);
    check_eq("split_lw_beats", nbeats, 2);

    run_access(1'b1, 2'd2, 1'b0, 32'h102, 32'h11223344, 32'h0, 32'h0, 0);
    check_eq("split_sw_wdata0", obs_wdata[0], 32'h33440000);
    check_eq("split_sw_mask0",  obs_mask[0], 4'b1100);
    check_eq("split_sw_wdata1", obs_wdata[1], 32'h00001122);
    check_eq("split_sw_mask1",  obs_mask[1], 4'b0011);

    run_access(1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0, 32'hBBAA0000, 32'h0000DDCC, 0);
    check_eq("wrap_addr0", obs_addr[0], 32'hFFFFFFFC);
    check_eq("wrap_addr1", obs_addr[1], 32'h00000000);
    check_eq("wrap_rsp",   rsp_data, 32'hDDCCBBAA);
`else
    run_access(1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 32'h0, 32'h0, 0);
    check_eq("misalign_err",    rsp_err, 1);
    check_eq("misalign_lat",    lat, 1);
    check_eq("misalign_no_bus", nvalid, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
